// File: rtl/eq_band_mixer.sv
// Ten-band gain/sum mixer: one shared 24x12 multiplier walks the bands, then saturates to 24 bits.
// Latency 11 clocks from accepted sample_valid to out_valid; optional round-half-up via EQ_BAND_MIXER_ROUND_EN.
// No backpressure: samples arriving while busy are dropped and flagged on the sticky overrun output.
module eq_band_mixer #(
    parameter int NBANDS = 10,
    parameter int GAIN_W = 12,
    parameter int ACC_W  = 40
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NBANDS*24-1:0]   bands_in,
    input  logic                   sample_valid,
    input  logic                   gain_wr,
    input  logic [3:0]             gain_addr,
    input  logic [GAIN_W-1:0]      gain_data,
    input  logic                   overrun_clr,
    output logic [23:0]            audio_out,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int SAMP_W = 24;
    localparam int PROD_W = SAMP_W + GAIN_W;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(12'h400);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-23){1'b0}}, {23{1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-23){1'b1}}, 23'd0};

    logic [1:0]                 state_q;
    logic [3:0]                 cnt_q;
    logic [NBANDS*SAMP_W-1:0]   hold_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic [GAIN_W-1:0]          shadow_q [NBANDS];
    logic [GAIN_W-1:0]          active_q [NBANDS];
    logic [GAIN_W-1:0]          shadow_nxt [NBANDS];

    logic                       accept;
    logic                       gain_we;
    logic signed [SAMP_W-1:0]   cur_samp;
    logic signed [GAIN_W-1:0]   cur_gain;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_rnd;
    logic signed [ACC_W-1:0]    shifted;
    logic [23:0]                sat_val;

    assign busy    = (state_q != ST_IDLE);
    assign accept  = sample_valid & enable & ~busy;
    assign gain_we = gain_wr & (gain_addr < 4'(NBANDS));

    // A write landing in the accept cycle must be part of the committed bank.
    always_comb begin
        for (int i = 0; i < NBANDS; i++) begin
            shadow_nxt[i] = shadow_q[i];
            if (gain_we && (gain_addr == 4'(i)))
                shadow_nxt[i] = gain_data;
        end
    end

    always_comb begin
        cur_samp = '0;
        cur_gain = '0;
        for (int i = 0; i < NBANDS; i++) begin
            if (cnt_q == 4'(i)) begin
                cur_samp = hold_q[i*SAMP_W +: SAMP_W];
                cur_gain = active_q[i];
            end
        end
    end

    assign prod     = cur_samp * cur_gain;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef EQ_BAND_MIXER_ROUND_EN
    assign acc_rnd = acc_q + ACC_W'(512);
`else
    assign acc_rnd = acc_q;
`endif

    assign shifted = acc_rnd >>> 10;

    always_comb begin
        if (shifted > SAT_MAX)
            sat_val = 24'h7FFFFF;
        else if (shifted < SAT_MIN)
            sat_val = 24'h800000;
        else
            sat_val = shifted[23:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            acc_q     <= '0;
            audio_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NBANDS; i++) begin
                shadow_q[i] <= GAIN_UNITY;
                active_q[i] <= GAIN_UNITY;
            end
        end else begin
            out_valid <= 1'b0;
            for (int i = 0; i < NBANDS; i++)
                shadow_q[i] <= shadow_nxt[i];

            if (sample_valid && enable && busy)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        hold_q  <= bands_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_MAC;
                        for (int i = 0; i < NBANDS; i++)
                            active_q[i] <= shadow_nxt[i];
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + prod_ext;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(NBANDS - 1))
                        state_q <= ST_SAT;
                end
                ST_SAT: begin
                    audio_out <= sat_val;
                    out_valid <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed bench for eq_band_mixer: reset, unity mix, saturation, gain commit, overrun, rounding, edge cases.
module tb_eq_band_mixer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [239:0]  bands_in;
    logic          sample_valid;
    logic          gain_wr;
    logic [3:0]    gain_addr;
    logic [11:0]   gain_data;
    logic          overrun_clr;
    logic [23:0]   audio_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    eq_band_mixer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bands_in     (bands_in),
        .sample_valid (sample_valid),
        .gain_wr      (gain_wr),
        .gain_addr    (gain_addr),
        .gain_data    (gain_data),
        .overrun_clr  (overrun_clr),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_bands(input logic [23:0] v);
        for (int i = 0; i < 10; i++) bands_in[i*24 +: 24] = v;
    endtask

    task automatic write_gain(input logic [3:0] a, input logic [11:0] d);
        gain_wr = 1'b1; gain_addr = a; gain_data = d;
        tick();
        gain_wr = 1'b0;
    endtask

    task automatic set_all_gains(input logic [11:0] d);
        for (int i = 0; i < 10; i++) write_gain(4'(i), d);
    endtask

    task automatic accept_sample();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    // Ticks until out_valid is seen; lat = cycles since the accept edge, -1 on timeout.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (audio_out !== 24'd0) begin errors++; $display("FAIL reset_audio got=%h want=000000", audio_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_unity(input string tag);
        int lat;
        for (int i = 0; i < 10; i++) bands_in[i*24 +: 24] = 24'(1000 * (i + 1));
        accept_sample();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b want=1", tag, busy); end
        wait_result(lat);
        checks++; if (lat !== 11) begin errors++; $display("FAIL %s_latency got=%0d want=11", tag, lat); end
        checks++; if (audio_out !== 24'd55000) begin errors++; $display("FAIL %s_value got=%0d want=55000", tag, audio_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_valid got=%b want=0", tag, busy); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_width got=%b want=0", tag, out_valid); end
        checks++; if (audio_out !== 24'd55000) begin errors++; $display("FAIL %s_hold got=%0d want=55000", tag, audio_out); end
    endtask

    task automatic test_saturation();
        int lat;
        set_all_gains(12'h7FF);
        set_all_bands(24'h7FFFFF);
        accept_sample();
        wait_result(lat);
        checks++; if (audio_out !== 24'h7FFFFF || lat !== 11) begin errors++; $display("FAIL sat_pos got=%h lat=%0d want=7fffff lat=11", audio_out, lat); end
        set_all_bands(24'h800000);
        accept_sample();
        wait_result(lat);
        checks++; if (audio_out !== 24'h800000 || lat !== 11) begin errors++; $display("FAIL sat_neg got=%h lat=%0d want=800000 lat=11", audio_out, lat); end
    endtask

    task automatic test_gains_overrun();
        int lat;
        set_all_gains(12'h400);
        write_gain(4'd3, 12'h000);
        write_gain(4'd12, 12'h000);
        set_all_bands(24'd100);
        accept_sample();
        tick();
        tick();
        write_gain(4'd3, 12'h400);
        set_all_bands(24'd7777);
        tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b want=1", overrun); end
        wait_result(lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL inflight_latency got=%0d want=6", lat); end
        checks++; if (audio_out !== 24'd900) begin errors++; $display("FAIL inflight_gain got=%0d want=900", audio_out); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got=%b want=0", overrun); end
        set_all_bands(24'd100);
        accept_sample();
        wait_result(lat);
        checks++; if (audio_out !== 24'd1000) begin errors++; $display("FAIL next_gain got=%0d want=1000", audio_out); end
        gain_wr = 1'b1; gain_addr = 4'd3; gain_data = 12'h000;
        accept_sample();
        gain_wr = 1'b0;
        wait_result(lat);
        checks++; if (audio_out !== 24'd900) begin errors++; $display("FAIL same_cycle_commit got=%0d want=900", audio_out); end
    endtask

    task automatic test_rounding();
        int lat;
        logic [23:0] exp_pos, exp_neg;
`ifdef EQ_BAND_MIXER_ROUND_EN
        exp_pos = 24'd1;
        exp_neg = 24'd0;
`else
        exp_pos = 24'd0;
        exp_neg = 24'hFFFFFF;
`endif
        set_all_gains(12'h000);
        write_gain(4'd0, 12'h200);
        set_all_bands(24'd0);
        bands_in[23:0] = 24'd1;
        accept_sample();
        wait_result(lat);
        checks++; if (audio_out !== exp_pos) begin errors++; $display("FAIL round_pos got=%h want=%h", audio_out, exp_pos); end
        bands_in[23:0] = 24'hFFFFFF;
        accept_sample();
        wait_result(lat);
        checks++; if (audio_out !== exp_neg) begin errors++; $display("FAIL round_neg got=%h want=%h", audio_out, exp_neg); end
    endtask

    task automatic test_reset_mid_mac();
        int seen = 0;
        set_all_bands(24'h123456);
        accept_sample();
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL midreset_flags got=%b%b%b want=000", busy, out_valid, overrun); end
        checks++; if (audio_out !== 24'd0) begin errors++; $display("FAIL midreset_audio got=%h want=000000", audio_out); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_valid got=%0d want=0", seen); end
    endtask

    task automatic test_enable_low();
        int seen = 0;
        int busy_seen = 0;
        enable = 1'b0;
        sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
            if (busy) busy_seen++;
        end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL enable_busy got=%0d want=0", busy_seen); end
        checks++; if (seen !== 0 || overrun !== 1'b0) begin errors++; $display("FAIL enable_accept got=%0d/%b want=0/0", seen, overrun); end
        enable = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; bands_in = '0; sample_valid = 1'b0;
        gain_wr = 1'b0; gain_addr = '0; gain_data = '0; overrun_clr = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_unity("unity");
        test_saturation();
        test_gains_overrun();
        test_rounding();
        test_reset_mid_mac();
        test_unity("post_reset");
        test_enable_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
